// File: rtl/tdm_demux4.sv
// tdm_demux4: receive side of the 4:1 lane multiplexer.
// Aligns to the frame-sync marker on a serial TDM line, de-interleaves each
// frame of 4 slots (SLOT_BITS bits each, MSB first) into parallel lane words,
// tracks frame lock and flags sync violations.
module tdm_demux4 #(
    parameter int SLOT_BITS = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     sdata_in,
    input  logic                     sync_in,
    output logic [4*SLOT_BITS-1:0]   lanes_out,
    output logic                     frame_valid,
    output logic                     locked,
    output logic                     sync_err
);

    // Bit counter is kept at least one bit wide; with SLOT_BITS=1 it simply stays 0.
    localparam int BW = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;

    localparam logic [BW-1:0] BIT_LAST   = BW'(SLOT_BITS - 1);
    // Position immediately after (slot 0, bit 0): the next bit of slot 0, or
    // slot 1 when a slot is only one bit long.
    localparam logic [BW-1:0] BIT_FIRST  = BW'((SLOT_BITS == 1) ? 0 : 1);
    localparam logic [1:0]    SLOT_FIRST = (SLOT_BITS == 1) ? 2'd1 : 2'd0;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    typedef logic [3:0][SLOT_BITS-1:0] shadow_t;

    state_t        state;
    logic [BW-1:0] bit_cnt;
    logic [1:0]    slot_cnt;
    shadow_t       shadow;

    logic          at_start;
    logic          at_last;
    logic [BW-1:0] bit_adv;
    logic [1:0]    slot_adv;
    shadow_t       shadow_shift;
    shadow_t       shadow_fresh;

    // Frame position decode, next position, and the two candidate shadow updates.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        at_start     = (bit_cnt == '0) && (slot_cnt == 2'd0);
        at_last      = (bit_cnt == BIT_LAST) && (slot_cnt == 2'd3);
        bit_adv      = bit_cnt;
        slot_adv     = slot_cnt;
        shadow_shift = shadow;
        shadow_fresh = '0;

        if (bit_cnt == BIT_LAST) begin
            bit_adv  = '0;
            slot_adv = slot_cnt + 2'd1;
        end else begin
            bit_adv  = bit_cnt + BW'(1);
        end

        // MSB-first assembly: shift the current slot left, new bit at the LSB.
        shadow_shift[slot_cnt] = (shadow[slot_cnt] << 1) | SLOT_BITS'(sdata_in);

        // Frame start: discard whatever was collected, the sync bit is slot 0's first bit.
        shadow_fresh[0][0] = sdata_in;
    end

    // Lock FSM, position counters, shadow registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shadow is a handful of flops, so it is reset along with everything else; a partial frame never survives reset.
            state       <= HUNT;
            bit_cnt     <= '0;
            slot_cnt    <= 2'd0;
            shadow      <= '0;
            lanes_out   <= '0;
            frame_valid <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register sees the pre-edge values of the others.
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;

            if (en) begin
                case (state)
                    HUNT: begin
                        if (sync_in) begin
                            shadow   <= shadow_fresh;
                            bit_cnt  <= BIT_FIRST;
                            slot_cnt <= SLOT_FIRST;
                            state    <= LOCKED;
                            locked   <= 1'b1;
                        end
                    end

                    LOCKED: begin
                        if (at_start) begin
                            if (sync_in) begin
                                shadow   <= shadow_fresh;
                                bit_cnt  <= BIT_FIRST;
                                slot_cnt <= SLOT_FIRST;
                            end else begin
                                // Expected marker missing: lose lock, drop the bit,
                                // keep the last good lanes_out.
                                sync_err <= 1'b1;
                                state    <= HUNT;
                                locked   <= 1'b0;
                            end
                        end else if (sync_in) begin
                            // Marker in the middle of a frame: restart the frame on this bit.
                            sync_err <= 1'b1;
                            shadow   <= shadow_fresh;
                            bit_cnt  <= BIT_FIRST;
                            slot_cnt <= SLOT_FIRST;
                        end else begin
                            shadow   <= shadow_shift;
                            bit_cnt  <= bit_adv;
                            slot_cnt <= slot_adv;
                            if (at_last) begin
                                lanes_out   <= shadow_shift;
                                frame_valid <= 1'b1;
                            end
                        end
                    end

                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed bench for tdm_demux4 with SLOT_BITS=2.
// Frames are written as the serial bit order slot0..slot3, MSB first.
module tb_tdm_demux4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       sdata_in;
    logic       sync_in;
    logic [7:0] lanes_out;
    logic       frame_valid;
    logic       locked;
    logic       sync_err;

    int checks   = 0;
    int failures = 0;
    int fv_cnt   = 0;
    int se_cnt   = 0;

    // Frame 10,01,11,00 -> lanes 8'h36 ; frame 11,11,00,01 -> lanes 8'h4F
    localparam logic [7:0] FRAME_A = 8'b10_01_11_00;
    localparam logic [7:0] FRAME_B = 8'b11_11_00_01;

    tdm_demux4 #(.SLOT_BITS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .sdata_in   (sdata_in),
        .sync_in    (sync_in),
        .lanes_out  (lanes_out),
        .frame_valid(frame_valid),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled on the falling edge away from the active edge.
    always @(negedge clk) begin
        if (frame_valid) fv_cnt++;
        if (sync_err)    se_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, settle 1 time unit after it.
    task automatic step(input logic e, input logic d, input logic s);
        en       = e;
        sdata_in = d;
        sync_in  = s;
        @(posedge clk);
        #1;
    endtask

    // Send the first n bits of a frame; optional sync on the first bit and
    // optional idle (en=0) cycle after every bit. last_fv is frame_valid right
    // after the final enabled bit's edge.
    task automatic send_bits(input logic [7:0] bits, input int n, input logic sync_first,
                             input logic toggle, output logic last_fv);
        last_fv = 1'b0;
        for (int i = 0; i < n; i++) begin
            step(1'b1, bits[7-i], (i == 0) && sync_first);
            last_fv = frame_valid;
            if (toggle) step(1'b0, 1'b0, 1'b0);
        end
    endtask

    logic fv;
    int   fv0;
    int   se0;

    initial begin
        rst = 1'b1;
        en = 1'b0; sdata_in = 1'b0; sync_in = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Reset state
        check("rst_lanes",  32'(lanes_out),   32'h00);
        check("rst_locked", 32'(locked),      32'd0);
        check("rst_fv",     32'(frame_valid), 32'd0);
        check("rst_serr",   32'(sync_err),    32'd0);

        // Hunting without a marker
        fv0 = fv_cnt;
        for (int i = 0; i < 5; i++) step(1'b1, i[0], 1'b0);
        check("hunt_locked", 32'(locked), 32'd0);
        check("hunt_fv_cnt", 32'(fv_cnt - fv0), 32'd0);

        // First frame, en always high
        fv0 = fv_cnt; se0 = se_cnt;
        send_bits(FRAME_A, 8, 1'b1, 1'b0, fv);
        check("a_fv_last",  32'(fv), 32'd1);
        check("a_lanes",    32'(lanes_out), 32'h36);
        check("a_locked",   32'(locked), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        check("a_fv_cnt",   32'(fv_cnt - fv0), 32'd1);
        check("a_serr_cnt", 32'(se_cnt - se0), 32'd0);

        // Same frame with en toggling; pulse must be exactly one cycle wide
        fv0 = fv_cnt;
        send_bits(FRAME_A, 8, 1'b1, 1'b1, fv);
        check("tog_fv_last",  32'(fv), 32'd1);
        check("tog_fv_after", 32'(frame_valid), 32'd0);
        check("tog_lanes",    32'(lanes_out), 32'h36);
        check("tog_fv_cnt",   32'(fv_cnt - fv0), 32'd1);

        // Back-to-back frames, no gap bit
        fv0 = fv_cnt;
        send_bits(FRAME_A, 8, 1'b1, 1'b0, fv);
        check("b2b_fv1",    32'(fv), 32'd1);
        check("b2b_lanes1", 32'(lanes_out), 32'h36);
        send_bits(FRAME_B, 8, 1'b1, 1'b0, fv);
        check("b2b_fv2",    32'(fv), 32'd1);
        check("b2b_lanes2", 32'(lanes_out), 32'h4F);
        step(1'b0, 1'b0, 1'b0);
        check("b2b_fv_cnt", 32'(fv_cnt - fv0), 32'd2);

        // Marker at slot2 bit0: broken frame dropped, new frame starts there
        fv0 = fv_cnt; se0 = se_cnt;
        send_bits(FRAME_B, 4, 1'b1, 1'b0, fv);
        step(1'b1, FRAME_A[7], 1'b1);
        check("mid_serr",   32'(sync_err), 32'd1);
        check("mid_locked", 32'(locked), 32'd1);
        check("mid_lanes_hold", 32'(lanes_out), 32'h4F);
        for (int i = 1; i < 8; i++) step(1'b1, FRAME_A[7-i], 1'b0);
        check("mid_fv_last", 32'(frame_valid), 32'd1);
        check("mid_lanes",   32'(lanes_out), 32'h36);
        step(1'b0, 1'b0, 1'b0);
        check("mid_fv_cnt",   32'(fv_cnt - fv0), 32'd1);
        check("mid_serr_cnt", 32'(se_cnt - se0), 32'd1);

        // Missing marker at expected frame start
        se0 = se_cnt;
        step(1'b1, 1'b1, 1'b0);
        check("miss_serr",   32'(sync_err), 32'd1);
        check("miss_locked", 32'(locked), 32'd0);
        check("miss_lanes",  32'(lanes_out), 32'h36);
        step(1'b1, 1'b0, 1'b0);
        check("miss_serr_pulse", 32'(sync_err), 32'd0);
        check("miss_serr_cnt",   32'(se_cnt - se0), 32'd1);

        // Reset in slot 1 (en high in the same cycle), then a full frame
        send_bits(FRAME_B, 3, 1'b1, 1'b0, fv);
        check("pre_rst_locked", 32'(locked), 32'd1);
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        check("rst2_lanes",  32'(lanes_out), 32'h00);
        check("rst2_locked", 32'(locked), 32'd0);
        fv0 = fv_cnt;
        send_bits(FRAME_B, 8, 1'b1, 1'b0, fv);
        check("rst2_fv_last", 32'(fv), 32'd1);
        check("rst2_lanes_b", 32'(lanes_out), 32'h4F);
        step(1'b0, 1'b0, 1'b0);
        check("rst2_fv_cnt",  32'(fv_cnt - fv0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
